// File: rtl/fb_write_arb_pkg.sv
// fb_pkg: shared types and geometry for the 160x120 mono framebuffer write path.
//   fb_wr_state_t : write-controller FSM states (idle / clear / done)
//   FB_WIDTH, FB_HEIGHT, FB_DEPTH, FB_ADDRW : default framebuffer geometry
//   fb_addr_t     : pixel address type for the default geometry
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDRW  = $clog2(FB_DEPTH);

    typedef logic [FB_ADDRW-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } fb_wr_state_t;

endpackage

// File: rtl/fb_write_arb_if.sv
// fb_write_arb_if: bundle between the drawing side and the framebuffer write controller.
//   clear_start/clear_colr/clear_busy/clear_done : clear sequencer control and status
//   rN_valid/rN_ready/rN_addr/rN_colr            : two requester write handshakes
//   fb_we/fb_addr/fb_colr                        : BRAM write pins
//   fb_oob                                       : out-of-range request pulse
// master = drawing engines / BRAM side, slave = fb_write_arb.
interface fb_write_arb_if #(
    parameter int ADDRW = 15,
    parameter int DATAW = 1
);

    logic             clear_start;
    logic [DATAW-1:0] clear_colr;
    logic             clear_busy;
    logic             clear_done;

    logic             r0_valid;
    logic             r0_ready;
    logic [ADDRW-1:0] r0_addr;
    logic [DATAW-1:0] r0_colr;

    logic             r1_valid;
    logic             r1_ready;
    logic [ADDRW-1:0] r1_addr;
    logic [DATAW-1:0] r1_colr;

    logic             fb_we;
    logic [ADDRW-1:0] fb_addr;
    logic [DATAW-1:0] fb_colr;
    logic             fb_oob;

    modport master (
        output clear_start, clear_colr,
        output r0_valid, r0_addr, r0_colr,
        output r1_valid, r1_addr, r1_colr,
        input  clear_busy, clear_done,
        input  r0_ready, r1_ready,
        input  fb_we, fb_addr, fb_colr, fb_oob
    );

    modport slave (
        input  clear_start, clear_colr,
        input  r0_valid, r0_addr, r0_colr,
        input  r1_valid, r1_addr, r1_colr,
        output clear_busy, clear_done,
        output r0_ready, r1_ready,
        output fb_we, fb_addr, fb_colr, fb_oob
    );

endinterface

// File: rtl/fb_write_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   clk    : clock
//   rst    : synchronous active-high reset (last pointer -> 1, so req[0] wins first)
//   en     : grant enable; no grant is given while low
//   req    : request vector
//   accept : transfer vector (req & gnt); updates the last pointer
//   gnt    : combinational grant; a grant never depends on its own request
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] accept,
    output logic [1:0] gnt
);

    logic last_q;

    // A requester is granted unless the other one is asking and it was served last.
    assign gnt[0] = en && (!req[1] || last_q);
    assign gnt[1] = en && (!req[0] || !last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept[0]) begin
            last_q <= 1'b0;
        end else if (accept[1]) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fb_write_arb.sv
// fb_write_arb: write-port controller for the 1bpp framebuffer BRAM.
// Shares the BRAM write port between two requesters (round-robin, valid/ready) and
// owns a clear sequencer that fills the whole buffer with one colour.
//   clk_pix : clock (only clock)
//   rst_pix : synchronous active-high reset
//   vbl     : vertical blanking; gates readies and clear start when FB_WRITE_VBL_EN
//   bus     : fb_write_arb_if.slave (clear control, requesters, BRAM write pins, fb_oob)
// Optional feature macro: FB_WRITE_VBL_EN (draw/clear-start only during blanking).
module fb_write_arb #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int FB_DATAW  = 1
) (
    input  logic           clk_pix,
    input  logic           rst_pix,
    input  logic           vbl,
    fb_write_arb_if.slave  bus
);

    import fb_pkg::*;

    localparam int FB_DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDRW = $clog2(FB_DEPTH);
    localparam logic [FB_ADDRW-1:0] LAST_ADDR = FB_ADDRW'(FB_DEPTH - 1);

    fb_wr_state_t        state_q;
    logic [FB_ADDRW-1:0] clr_cnt_q;
    logic [FB_DATAW-1:0] clr_colr_q;
    logic                fb_we_q;
    logic [FB_ADDRW-1:0] fb_addr_q;
    logic [FB_DATAW-1:0] fb_colr_q;
    logic                clear_busy_q;
    logic                clear_done_q;
    logic                fb_oob_q;

    logic                vbl_ok;
    logic                start_acc;
    logic                arb_en;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic [1:0]          xfer;
    logic [FB_ADDRW-1:0] acc_addr;
    logic [FB_DATAW-1:0] acc_colr;

`ifdef FB_WRITE_VBL_EN
    assign vbl_ok = vbl;
`else
    logic unused_vbl;
    assign unused_vbl = vbl;
    assign vbl_ok     = 1'b1;
`endif

    // clear_start wins over requesters, so it also masks the readies in its cycle.
    assign start_acc = (state_q == StIdle) && bus.clear_start && vbl_ok;
    assign arb_en    = !rst_pix && (state_q == StIdle) && !start_acc && vbl_ok;

    assign req  = {bus.r1_valid, bus.r0_valid};
    assign xfer = req & gnt;

    rr_arb2 u_rr_arb2 (
        .clk    (clk_pix),
        .rst    (rst_pix),
        .en     (arb_en),
        .req    (req),
        .accept (xfer),
        .gnt    (gnt)
    );

    assign bus.r0_ready = gnt[0];
    assign bus.r1_ready = gnt[1];

    assign acc_addr = xfer[1] ? bus.r1_addr : bus.r0_addr;
    assign acc_colr = xfer[1] ? bus.r1_colr : bus.r0_colr;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q      <= StIdle;
            clr_cnt_q    <= '0;
            clr_colr_q   <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_colr_q    <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            fb_oob_q     <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            clear_done_q <= 1'b0;
            fb_oob_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_acc) begin
                        // Address 0 is issued right away so writes appear from the
                        // cycle after acceptance; the counter tracks the write on the pins.
                        state_q      <= StClear;
                        clr_cnt_q    <= '0;
                        clr_colr_q   <= bus.clear_colr;
                        clear_busy_q <= 1'b1;
                        fb_we_q      <= 1'b1;
                        fb_addr_q    <= '0;
                        fb_colr_q    <= bus.clear_colr;
                    end else if (|xfer) begin
                        if (acc_addr > LAST_ADDR) begin
                            fb_oob_q <= 1'b1;
                        end else begin
                            fb_we_q   <= 1'b1;
                            fb_addr_q <= acc_addr;
                            fb_colr_q <= acc_colr;
                        end
                    end
                end
                StClear: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q      <= StDone;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= clr_cnt_q + 1'b1;
                        fb_colr_q <= clr_colr_q;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_colr    = fb_colr_q;
    assign bus.clear_busy = clear_busy_q;
    assign bus.clear_done = clear_done_q;
    assign bus.fb_oob     = fb_oob_q;

endmodule

// File: tb/tb_fb_write_arb.sv
// tb_fb_write_arb: directed self-checking bench for fb_write_arb.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_fb_write_arb;

    import fb_pkg::*;

    localparam int DEPTH = FB_DEPTH;

    logic clk_pix = 1'b0;
    logic rst_pix;
    logic vbl;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk_pix = ~clk_pix;

    fb_write_arb_if #(.ADDRW(FB_ADDRW), .DATAW(1)) bus ();

    fb_write_arb #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .FB_DATAW  (1)
    ) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .vbl     (vbl),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        int bad;
        int n_done;
        logic exp0;

        rst_pix         = 1'b1;
        vbl             = 1'b1;
        bus.clear_start = 1'b0;
        bus.clear_colr  = 1'b0;
        bus.r0_valid    = 1'b0;
        bus.r0_addr     = '0;
        bus.r0_colr     = 1'b0;
        bus.r1_valid    = 1'b0;
        bus.r1_addr     = '0;
        bus.r1_colr     = 1'b0;

        // Reset values; valids held high to show readies stay low in reset.
        tick();
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 15'd5;
        bus.r0_colr  = 1'b1;
        bus.r1_valid = 1'b1;
        tick();
        chk("rst_r0_ready", bus.r0_ready, 0);
        chk("rst_r1_ready", bus.r1_ready, 0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_colr", bus.fb_colr, 0);
        chk("rst_busy", bus.clear_busy, 0);
        chk("rst_done", bus.clear_done, 0);
        chk("rst_oob", bus.fb_oob, 0);

        // Single requester straight after reset.
        bus.r1_valid = 1'b0;
        rst_pix      = 1'b0;
        #1;
        chk("first_r0_ready", bus.r0_ready, 1);
        tick();
        bus.r0_valid = 1'b0;
        chk("first_fb_we", bus.fb_we, 1);
        chk("first_fb_addr", bus.fb_addr, 5);
        chk("first_fb_colr", bus.fb_colr, 1);
        tick();
        chk("first_fb_we_drop", bus.fb_we, 0);

        // Contention after a fresh reset: r0 first, then alternate.
        rst_pix = 1'b1;
        tick();
        rst_pix      = 1'b0;
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 15'd10;
        bus.r0_colr  = 1'b1;
        bus.r1_valid = 1'b1;
        bus.r1_addr  = 15'd20;
        bus.r1_colr  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp0 = (i % 2 == 0);
            #1;
            chk("cont_r0_ready", bus.r0_ready, exp0);
            chk("cont_r1_ready", bus.r1_ready, !exp0);
            tick();
            chk("cont_fb_we", bus.fb_we, 1);
            chk("cont_fb_addr", bus.fb_addr, exp0 ? 10 : 20);
            chk("cont_fb_colr", bus.fb_colr, exp0 ? 1 : 0);
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        tick();
        chk("cont_fb_we_drop", bus.fb_we, 0);

        // Out-of-range request is consumed without a write.
        bus.r1_valid = 1'b1;
        bus.r1_addr  = 15'd19200;
        bus.r1_colr  = 1'b1;
        #1;
        chk("oob_r1_ready", bus.r1_ready, 1);
        tick();
        bus.r1_valid = 1'b0;
        chk("oob_fb_we", bus.fb_we, 0);
        chk("oob_pulse", bus.fb_oob, 1);
        tick();
        chk("oob_pulse_end", bus.fb_oob, 0);
        chk("oob_fb_we_after", bus.fb_we, 0);

        // Clear start and r0 valid together: clear wins, r0 waits.
        bus.clear_start = 1'b1;
        bus.clear_colr  = 1'b0;
        bus.r0_valid    = 1'b1;
        bus.r0_addr     = 15'd7;
        bus.r0_colr     = 1'b1;
        #1;
        chk("start_r0_ready", bus.r0_ready, 0);
        tick();
        bus.clear_start = 1'b0;
        bad    = 0;
        n_done = 0;
        for (int k = 0; k < DEPTH; k++) begin
            // A second start mid-clear must be ignored.
            bus.clear_start = (k == 50);
            if (!(bus.fb_we === 1'b1 && bus.fb_addr === 15'(k) && bus.fb_colr === 1'b0 &&
                  bus.clear_busy === 1'b1 && bus.r0_ready === 1'b0 &&
                  bus.r1_ready === 1'b0)) begin
                bad++;
            end
            if (bus.clear_done === 1'b1) n_done++;
            tick();
        end
        bus.clear_start = 1'b0;
        chk("clear_bad_cycles", bad, 0);
        chk("clear_early_done", n_done, 0);
        chk("clear_done_pulse", bus.clear_done, 1);
        chk("clear_busy_fall", bus.clear_busy, 0);
        chk("clear_done_we", bus.fb_we, 0);
        chk("clear_done_r0_ready", bus.r0_ready, 0);
        chk("clear_done_r1_ready", bus.r1_ready, 0);
        tick();
        chk("clear_done_end", bus.clear_done, 0);
        chk("post_clear_r0_ready", bus.r0_ready, 1);
        tick();
        bus.r0_valid = 1'b0;
        chk("post_clear_fb_we", bus.fb_we, 1);
        chk("post_clear_fb_addr", bus.fb_addr, 7);
        chk("post_clear_fb_colr", bus.fb_colr, 1);

        // Reset in the middle of a clear.
        bus.clear_start = 1'b1;
        bus.clear_colr  = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        chk("midclr_fb_addr", bus.fb_addr, 100);
        chk("midclr_fb_colr", bus.fb_colr, 1);
        chk("midclr_busy", bus.clear_busy, 1);
        rst_pix      = 1'b1;
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 15'd3;
        bus.r0_colr  = 1'b0;
        tick();
        chk("midclr_rst_we", bus.fb_we, 0);
        chk("midclr_rst_addr", bus.fb_addr, 0);
        chk("midclr_rst_colr", bus.fb_colr, 0);
        chk("midclr_rst_busy", bus.clear_busy, 0);
        chk("midclr_rst_done", bus.clear_done, 0);
        chk("midclr_rst_r0_ready", bus.r0_ready, 0);
        rst_pix = 1'b0;
        #1;
        chk("midclr_r0_ready", bus.r0_ready, 1);
        tick();
        bus.r0_valid = 1'b0;
        chk("midclr_r0_we", bus.fb_we, 1);
        chk("midclr_r0_addr", bus.fb_addr, 3);
        n_done = (bus.clear_done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.clear_done === 1'b1) n_done++;
        end
        chk("midclr_no_done", n_done, 0);

        // Blanking gate.
        vbl          = 1'b0;
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 15'd9;
        bus.r0_colr  = 1'b1;
`ifdef FB_WRITE_VBL_EN
        #1;
        chk("vbl_low_ready", bus.r0_ready, 0);
        tick();
        chk("vbl_low_we", bus.fb_we, 0);
        tick();
        chk("vbl_low_we2", bus.fb_we, 0);
        vbl = 1'b1;
        #1;
        chk("vbl_high_ready", bus.r0_ready, 1);
        tick();
`else
        #1;
        chk("vbl_ignored_ready", bus.r0_ready, 1);
        tick();
`endif
        bus.r0_valid = 1'b0;
        vbl          = 1'b1;
        chk("vbl_fb_we", bus.fb_we, 1);
        chk("vbl_fb_addr", bus.fb_addr, 9);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fb_write_arb.md
# fb_write_arb

Write-port controller for the 1-bit-per-pixel framebuffer BRAM (`bram_sdp_4p` write side) in the 160x120 mono design. It shares the single write port between two drawing requesters using round-robin arbitration with valid/ready handshakes. It also owns a built-in clear sequencer that fills the whole buffer with one colour. It sits between the drawing engines and the BRAM `we/addr_write/data_in` pins, in the same clock domain as the display read path.

## Interface
Parameters:
- `FB_WIDTH`, 160, framebuffer width (pixels)
- `FB_HEIGHT`, 120, framebuffer height (pixels)
- `FB_DATAW`, 1, colour bits per pixel
- `FB_ADDRW`, `$clog2(FB_WIDTH*FB_HEIGHT)`, address width; derived, not overridden

Ports:
- `clk_pix`  in  1  clock; the only clock
- `rst_pix`  in  1  reset; synchronous, active-high
- `vbl`  in  1  high during vertical blanking; used only when `FB_WRITE_VBL_EN` is defined
- `clear_start`  in  1  one-cycle request to start a buffer clear
- `clear_colr`  in  `FB_DATAW`  fill colour; sampled on the cycle `clear_start` is accepted
- `clear_busy`  out  1  high while the clear is in progress
- `clear_done`  out  1  one-cycle pulse when the clear finishes
- `r0_valid`, `r1_valid`  in  1  requester write valid
- `r0_ready`, `r1_ready`  out  1  requester write ready
- `r0_addr`, `r1_addr`  in  `FB_ADDRW`  pixel address
- `r0_colr`, `r1_colr`  in  `FB_DATAW`  pixel colour
- `fb_we`  out  1  BRAM write enable
- `fb_addr`  out  `FB_ADDRW`  BRAM write address
- `fb_colr`  out  `FB_DATAW`  BRAM write data
- `fb_oob`  out  1  one-cycle pulse when an accepted request had an address ≥ DEPTH

## Operation
- DEPTH = `FB_WIDTH*FB_HEIGHT`.
- FSM states are IDLE, CLEAR and DONE. Reset enters IDLE.
- **IDLE:**
  - `clear_start` → go to CLEAR, latch `clear_colr`, and set the clear counter to 0.
  - `clear_start` wins over any requester valid in the same cycle; `rN_ready` is 0 in that cycle.
- **CLEAR:**
  - Each cycle, write the latched colour at the counter value, then increment the counter.
  - After writing DEPTH-1, go to DONE.
  - Both readies are 0 and `clear_busy` is 1.
  - `clear_start` is ignored.
- **DONE:**
  - One cycle with `clear_done`=1 and both readies 0.
  - Then go to IDLE.
- **Arbitration (IDLE only):**
  - `rN_ready` is combinational from state, the `last` pointer, the other requester's valid and gating. It never depends on its own valid.
  - Only one requester is valid → that requester gets ready=1.
  - Both are valid → ready goes to the requester that is not `last`.
  - A transfer happens when valid && ready. After a transfer, `last` becomes the granted requester.
  - `last` resets to 1, so r0 wins the first contention.
  - A requester holds `addr`/`colr` stable while valid and not ready.
- **Out-of-range handling:** an accepted request with address ≥ DEPTH is consumed, produces no write, and pulses `fb_oob` on the next cycle.
- **Reset mid-clear:** abandon the clear and return to IDLE. `clear_done` does not pulse. Buffer contents are partial.

## Timing
- All outputs are registered. Reset values: `fb_we`=0, `fb_addr`=0, `fb_colr`=0, `clear_busy`=0, `clear_done`=0, `fb_oob`=0. The readies are combinational and evaluate to 0 during reset.
- **Requester write latency:** a transfer at edge N makes `fb_we`=1 with the accepted addr/colr in cycle N+1. Throughput is one write per cycle.
- **Clear timing:**
  - `clear_start` accepted at edge N → `clear_busy`=1 from N+1.
  - Writes to addresses 0..DEPTH-1 appear in cycles N+1..N+DEPTH.
  - `clear_done` pulses in cycle N+DEPTH+1, and `clear_busy` falls in the same cycle.
  - Requesters can get ready again in cycle N+DEPTH+2.
- **Counter width:** the counter is `FB_ADDRW` bits. The terminal compare is against DEPTH-1, so it never wraps.

## Configuration
- `FB_WRITE_VBL_EN` defined:
  - Requester readies are additionally ANDed with `vbl`, so drawing happens only in vertical blanking and never tears.
  - The clear still starts only when `vbl`=1, but once started it runs to completion regardless of `vbl`.
- Not defined: `vbl` is ignored, and requesters and clear proceed at any time.

## Structure
- Package `fb_pkg` holds:
  - the state enum `fb_wr_state_t` (IDLE, CLEAR, DONE);
  - localparams `FB_WIDTH`, `FB_HEIGHT`, `FB_DEPTH`, `FB_ADDRW`;
  - typedef `fb_addr_t`.
- Sub-module `rr_arb2` is a two-way round-robin grant with the `last` pointer: inputs are `req[1:0]` and `en`; outputs are `gnt[1:0]`, and `last` updates on `accept`.

## Test plan
- **Reset default:** after reset, r0_valid=1 (addr 5, colr 1) → `fb_we`=1, `fb_addr`=5, `fb_colr`=1 exactly one cycle after the transfer.
- **Contention:** r0 and r1 both valid continuously for 6 cycles → grants alternate r0,r1,r0,r1,r0,r1, and `fb_addr` alternates between the two addresses.
- **Clear:** `clear_start` with colr 0 → 19200 consecutive writes to addresses 0..19199, then one `clear_done` pulse. A ready asserted during the clear fails the test.
- **Simultaneous start and valid:** `clear_start` and r0_valid in the same cycle → clear wins, r0_ready=0 throughout, and r0 is accepted 19202 cycles later.
- **Out of range:** r1 writes address 19200 → accepted, `fb_we` stays 0, `fb_oob` pulses once.
- **Reset mid-clear:** reset at clear counter 100 → outputs return to reset values, there is no `clear_done`, and r0 is served immediately afterwards.
- **With `FB_WRITE_VBL_EN`:** r0_valid held with vbl=0 → no ready; vbl rises → transfer in the same cycle.
